// File: rtl/ring_read_fetcher_pkg.sv
// Shared definitions for the ring read fetcher.
//   fetch_state_t : sequencer states
//   FIFO_DEPTH    : output FIFO entry count
//   ring_next()   : advance a ring pointer, wrapping to 0 after depth-1
package ring_read_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  localparam int FIFO_DEPTH = 2;

  // depth need not be a power of two, so wrap is an explicit compare.
  function automatic logic [31:0] ring_next(input logic [31:0] ptr,
                                            input logic [31:0] depth);
    if (ptr >= depth - 32'd1) return 32'd0;
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ring_read_fetcher_fifo.sv
// Two-entry output FIFO carrying {last, data}.
//   clk, nRst : clock, async active-low reset
//   flush     : empty the FIFO (wins over push/pop)
//   push, din : write one entry
//   pop       : remove head (caller only pops when count != 0)
//   dout      : head entry (entry 0)
//   count     : occupancy 0..2
// Push and pop may coincide at any occupancy, including full.
module ring_fifo2
  import ring_read_fetcher_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;

  assign dout = e0;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          if (count != 2'(FIFO_DEPTH)) count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ring_read_fetcher.sv
// Ring read fetcher: takes a burst command (offset, count), walks a circular
// memory region issuing one-word reads over the reader's request/done
// handshake, and streams words through a 2-entry FIFO with valid/ready.
//   clk, nRst                         : clock, async active-low reset
//   cmd_valid/offset/count, cmd_ready : burst command (accepted in IDLE)
//   abort                             : cancel the running burst
//   rd_request, rd_addr               : read request to the reader
//   rd_done, rd_data                  : read completion from the reader
//   out_valid/data/last, out_ready    : downstream word stream
//   burst_done                        : pulse after the last word is popped
//   busy                              : burst running or FIFO not empty
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// FETCH | requesting words from the reader
// STALL | FIFO too full to start another read
// DRAIN | aborted; wait for any in-flight read, FIFO flushed
module ring_read_fetcher
  import ring_read_fetcher_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BASE   = 0,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              cmd_valid,
  input  logic [ADDR_W-1:0] cmd_offset,
  input  logic [ADDR_W:0]   cmd_count,
  output logic              cmd_ready,
  input  logic              abort,
  output logic              rd_request,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              burst_done,
  output logic              busy
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_nxt;
  logic [ADDR_W:0]   remain_q;
  logic              inflight_q;
  logic              burst_done_q;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic              push, pop, flush, cont, last_word, accept;

  assign ptr_nxt   = ADDR_W'(ring_next(32'(ptr_q), 32'(DEPTH)));
  assign last_word = (remain_q == (ADDR_W+1)'(1));
  assign accept    = (state_q == ST_IDLE) && cmd_valid && (cmd_count != '0);
  assign pop       = out_valid && out_ready;
  // Keep requesting only if more words remain and, after this write and a
  // possible pop, the FIFO still has a free entry for the next word.
  assign cont      = (remain_q > (ADDR_W+1)'(1)) &&
                     ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (fifo_count <= 2'd1) ? ST_FETCH : ST_STALL;
      ST_FETCH: begin
        if (abort)        state_d = ST_DRAIN;
        else if (rd_done) begin
          if (last_word)  state_d = ST_IDLE;
          else if (!cont) state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (abort)                     state_d = ST_DRAIN;
        else if (fifo_count <= 2'd1)   state_d = ST_FETCH;
      end
      ST_DRAIN: if (!inflight_q || rd_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == ST_IDLE);
    rd_request = (state_q == ST_FETCH) && !abort && !(rd_done && !cont);
    push       = (state_q == ST_FETCH) && !abort && rd_done;
    flush      = (state_q == ST_DRAIN) || (abort && (state_q != ST_IDLE));
    busy       = (state_q != ST_IDLE) || (fifo_count != 2'd0);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ptr_q        <= '0;
      rd_addr      <= ADDR_W'(BASE);
      remain_q     <= '0;
      inflight_q   <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= pop && fifo_head[DATA_W] && !flush;
      // A request seen at an edge commits the reader; only a done with the
      // request low leaves nothing outstanding.
      inflight_q   <= rd_done ? rd_request : (inflight_q | rd_request);
      if (accept) begin
        ptr_q    <= cmd_offset;
        rd_addr  <= ADDR_W'(BASE) + cmd_offset;
        remain_q <= cmd_count;
      end else if (push) begin
        ptr_q    <= ptr_nxt;
        rd_addr  <= ADDR_W'(BASE) + ptr_nxt;
        remain_q <= remain_q - (ADDR_W+1)'(1);
      end
    end
  end

  ring_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk   (clk),
    .nRst  (nRst),
    .flush (flush),
    .push  (push),
    .din   ({last_word, rd_data}),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = fifo_head[DATA_W-1:0];
  assign out_last   = fifo_head[DATA_W];
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_ring_read_fetcher.sv
module tb_ring_read_fetcher;

  localparam int BASE_T  = 16'h100;
  localparam int DEPTH_T = 8;

  logic        clk = 1'b0;
  logic        nRst;
  logic        cmd_valid;
  logic [15:0] cmd_offset;
  logic [16:0] cmd_count;
  logic        cmd_ready;
  logic        abort;
  logic        rd_request;
  logic [15:0] rd_addr;
  logic        rd_done;
  logic [15:0] rd_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        burst_done;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] salt;
  logic [16:0] exp_word_q[$];
  logic [16:0] got_word_q[$];
  logic [15:0] exp_addr_q[$];
  logic [15:0] got_addr_q[$];
  int bd_count, req_cycles, reads_started, reads_done;
  int lat_fixed = -1;
  int ready_pct = 100;
  bit rbusy;
  int rcnt;

  ring_read_fetcher #(.ADDR_W(16), .DATA_W(16), .BASE(BASE_T), .DEPTH(DEPTH_T)) dut (
    .clk(clk), .nRst(nRst),
    .cmd_valid(cmd_valid), .cmd_offset(cmd_offset), .cmd_count(cmd_count), .cmd_ready(cmd_ready),
    .abort(abort),
    .rd_request(rd_request), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .burst_done(burst_done), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return (a * 16'h3B9D) ^ salt;
  endfunction

  function automatic logic [15:0] ring_addr(input int off, input int i);
    return 16'(BASE_T + (off + i) % DEPTH_T);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reader model: a request seen at a clock edge starts a read that
  // completes with a one-cycle rd_done after a random latency.
  initial begin
    rd_done = 1'b0; rd_data = '0; rbusy = 1'b0; rcnt = 0;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        rbusy = 1'b0; rd_done = 1'b0;
      end else begin
        if (rbusy && rcnt == 0) begin
          rd_done = 1'b1;
          rd_data = word_of(rd_addr);
          got_addr_q.push_back(rd_addr);
          rbusy = 1'b0;
          reads_done++;
        end else begin
          rd_done = 1'b0;
          if (rbusy) rcnt--;
        end
        #1;
        if (nRst && rd_request && !rbusy) begin
          rbusy = 1'b1;
          rcnt  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(3));
          reads_started++;
        end
      end
    end
  end

  // Output monitor, sampled mid-cycle before the popping edge.
  initial forever begin
    @(negedge clk);
    #3;
    if (nRst) begin
      if (out_valid && out_ready) got_word_q.push_back({out_last, out_data});
      if (burst_done) bd_count++;
      if (rd_request) req_cycles++;
    end
  end

  task automatic check_reset(input string p);
    check({p, "_cmd_ready"},  32'(cmd_ready), 32'd1);
    check({p, "_rd_request"}, 32'(rd_request), 32'd0);
    check({p, "_rd_addr"},    32'(rd_addr), 32'(BASE_T));
    check({p, "_out_valid"},  32'(out_valid), 32'd0);
    check({p, "_out_data"},   32'(out_data), 32'd0);
    check({p, "_out_last"},   32'(out_last), 32'd0);
    check({p, "_burst_done"}, 32'(burst_done), 32'd0);
    check({p, "_busy"},       32'(busy), 32'd0);
  endtask

  task automatic clear_obs();
    got_word_q.delete(); got_addr_q.delete();
    exp_word_q.delete(); exp_addr_q.delete();
    bd_count = 0; req_cycles = 0; reads_started = 0; reads_done = 0;
  endtask

  task automatic start_burst(input int off, input int cnt);
    clear_obs();
    salt = 16'($urandom);
    for (int i = 0; i < cnt; i++) begin
      exp_addr_q.push_back(ring_addr(off, i));
      exp_word_q.push_back({(i == cnt - 1), word_of(ring_addr(off, i))});
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_offset = 16'(off); cmd_count = 17'(cnt);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2;
    check("first_req", 32'(rd_request), 32'd1);
    check("first_addr", 32'(rd_addr), 32'(BASE_T + off));
  endtask

  task automatic finish_burst(input int cnt, input bit hit_busy);
    int cyc;
    bit to;
    cyc = 0; to = 1'b0;
    while (!(got_word_q.size() == cnt && !busy)) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(99) < ready_pct);
      if (hit_busy && cyc == 2) begin
        cmd_valid = 1'b1; cmd_offset = 16'd0; cmd_count = 17'd1;
      end else begin
        cmd_valid = 1'b0;
      end
      if (cyc > 500) begin
        to = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("burst_timeout", 32'(to), 32'd0);
    check("word_count", 32'(got_word_q.size()), 32'(cnt));
    for (int i = 0; i < cnt && i < got_word_q.size(); i++)
      check($sformatf("word%0d", i), 32'(got_word_q[i]), 32'(exp_word_q[i]));
    check("addr_count", 32'(got_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < got_addr_q.size(); i++)
      check($sformatf("addr%0d", i), 32'(got_addr_q[i]), 32'(exp_addr_q[i]));
    check("burst_done_pulses", 32'(bd_count), 32'd1);
  endtask

  task automatic run_burst(input int off, input int cnt, input bit hit_busy);
    start_burst(off, cnt);
    finish_burst(cnt, hit_busy);
  endtask

  initial begin
    int cyc;
    cmd_valid = 1'b0; cmd_offset = '0; cmd_count = '0;
    abort = 1'b0; out_ready = 1'b1;
    clear_obs();
    nRst = 1'b1;
    #1 nRst = 1'b0;
    #1;
    check_reset("reset");
    repeat (3) @(negedge clk);
    nRst = 1'b1;

    // directed: plain burst and wrapping burst
    ready_pct = 100;
    run_burst(2, 3, 1'b0);
    run_burst(6, 4, 1'b0);

    // stall with downstream blocked
    out_ready = 1'b0;
    ready_pct = 0;
    start_burst(1, 5);
    out_ready = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    check("stall_reads", 32'(reads_done), 32'd2);
    check("stall_req_low", 32'(rd_request), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_no_pop", 32'(got_word_q.size()), 32'd0);
    ready_pct = 100;
    finish_burst(5, 1'b0);

    // abort with a read in flight
    lat_fixed = 4;
    out_ready = 1'b1;
    start_burst(0, 4);
    cyc = 0;
    while (reads_started < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_second_req", 32'(reads_started), 32'd2);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cyc = 0;
    while ((busy || reads_done != reads_started) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (10) @(negedge clk);
    #2;
    check("abort_reads_started", 32'(reads_started), 32'd2);
    check("abort_reads_done", 32'(reads_done), 32'd2);
    check("abort_no_burst_done", 32'(bd_count), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    lat_fixed = -1;

    // zero-count command is ignored
    clear_obs();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_offset = 16'd3; cmd_count = 17'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    check("zero_req_cycles", 32'(req_cycles), 32'd0);
    check("zero_reads", 32'(reads_started), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_cmd_ready", 32'(cmd_ready), 32'd1);

    // command while busy is ignored
    ready_pct = 60;
    run_burst(5, 9, 1'b1);

    // reset mid-burst, then a fresh burst
    ready_pct = 50;
    start_burst(3, 10);
    repeat (6) @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    check_reset("midreset");
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    ready_pct = 100;
    out_ready = 1'b1;
    run_burst(5, 6, 1'b0);

    // randomized bursts
    for (int k = 0; k < 10; k++) begin
      ready_pct = int'($urandom_range(100, 30));
      run_burst(int'($urandom_range(DEPTH_T - 1)), int'($urandom_range(12, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
